// File: rtl/uivtc.sv
// Video timing controller: generates the sync/blank raster, active-pixel position and
// frame-start pulse for the video pipeline. Frames always run to completion once started.
module uivtc #(
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        vtc_clk_i,
    input  logic        vtc_rst_i,
    input  logic        vtc_en_i,
    output logic        vtc_vs_o,
    output logic        vtc_hs_o,
    output logic        vtc_de_o,
    output logic [11:0] vtc_x_o,
    output logic [11:0] vtc_y_o,
    output logic        vtc_sof_o,
    output logic        vtc_busy_o
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    // 13-bit bounds so an active window ending exactly at 4096 still compares correctly
    localparam logic [12:0] H_SYNC_END = 13'(H_SYNC);
    localparam logic [12:0] V_SYNC_END = 13'(V_SYNC);
    localparam logic [12:0] H_ACT_BEG  = 13'(H_SYNC + H_BP);
    localparam logic [12:0] H_ACT_END  = 13'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [12:0] V_ACT_BEG  = 13'(V_SYNC + V_BP);
    localparam logic [12:0] V_ACT_END  = 13'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic        h_last, frame_last;
    logic        in_frame, h_act, v_act, de_d;

    assign h_last     = (h_cnt == H_LAST);
    assign frame_last = h_last && (v_cnt == V_LAST);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        case (state)
            ST_IDLE: begin
                h_nxt = 12'd0;
                v_nxt = 12'd0;
                if (vtc_en_i) state_nxt = ST_RUN;
            end
            default: begin
                if (h_last) begin
                    h_nxt = 12'd0;
                    v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
                end else begin
                    h_nxt = h_cnt + 12'd1;
                end
                // en only decides whether the next frame starts; the current one always finishes
                if (vtc_en_i)        state_nxt = ST_RUN;
                else if (frame_last) state_nxt = ST_IDLE;
                else                 state_nxt = ST_STOP;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vtc_clk_i or posedge vtc_rst_i) begin
        if (vtc_rst_i) begin
            state <= ST_IDLE;
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    assign in_frame = (state != ST_IDLE);
    assign h_act    = ({1'b0, h_cnt} >= H_ACT_BEG) && ({1'b0, h_cnt} < H_ACT_END);
    assign v_act    = ({1'b0, v_cnt} >= V_ACT_BEG) && ({1'b0, v_cnt} < V_ACT_END);
    assign de_d     = in_frame && h_act && v_act;

    // Outputs are registered from the current counters, giving one cycle of latency
    always_ff @(posedge vtc_clk_i or posedge vtc_rst_i) begin
        if (vtc_rst_i) begin
            vtc_hs_o   <= ~HS_POL;
            vtc_vs_o   <= ~VS_POL;
            vtc_de_o   <= 1'b0;
            vtc_x_o    <= 12'd0;
            vtc_y_o    <= 12'd0;
            vtc_sof_o  <= 1'b0;
            vtc_busy_o <= 1'b0;
        end else begin
            vtc_hs_o   <= (in_frame && ({1'b0, h_cnt} < H_SYNC_END)) ? HS_POL : ~HS_POL;
            vtc_vs_o   <= (in_frame && ({1'b0, v_cnt} < V_SYNC_END)) ? VS_POL : ~VS_POL;
            vtc_de_o   <= de_d;
            vtc_x_o    <= de_d ? (h_cnt - H_ACT_BEG[11:0]) : 12'd0;
            vtc_y_o    <= de_d ? (v_cnt - V_ACT_BEG[11:0]) : 12'd0;
            vtc_sof_o  <= in_frame && (h_cnt == 12'd0) && (v_cnt == 12'd0);
            vtc_busy_o <= in_frame;
        end
    end

endmodule

// File: tb/tb_uivtc.sv
// Directed bench for uivtc with a reduced 14x7 raster; a second instance uses inverted
// sync polarity and shares all inputs with the first.
module tb_uivtc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;

    logic        vs_p, hs_p, de_p, sof_p, busy_p;
    logic [11:0] x_p, y_p;
    logic        vs_n, hs_n, de_n, sof_n, busy_n;
    logic [11:0] x_n, y_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uivtc #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut (
        .vtc_clk_i(clk), .vtc_rst_i(rst), .vtc_en_i(en),
        .vtc_vs_o(vs_p), .vtc_hs_o(hs_p), .vtc_de_o(de_p),
        .vtc_x_o(x_p), .vtc_y_o(y_p), .vtc_sof_o(sof_p), .vtc_busy_o(busy_p)
    );

    uivtc #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_n (
        .vtc_clk_i(clk), .vtc_rst_i(rst), .vtc_en_i(en),
        .vtc_vs_o(vs_n), .vtc_hs_o(hs_n), .vtc_de_o(de_n),
        .vtc_x_o(x_n), .vtc_y_o(y_n), .vtc_sof_o(sof_n), .vtc_busy_o(busy_n)
    );

    // {busy, sof, vs, hs, de, x, y}
    logic [28:0] obs_p, obs_n;
    assign obs_p = {busy_p, sof_p, vs_p, hs_p, de_p, x_p, y_p};
    assign obs_n = {busy_n, sof_n, vs_n, hs_n, de_n, x_n, y_n};

    // Expected outputs at frame cycle k: line = 2 sync, 2 bp, 8 active, 2 fp; frame = 1 sync, 1 bp, 4 active, 1 fp
    function automatic logic [28:0] exp_out(int k, logic hpol, logic vpol);
        int          h  = k % 14;
        int          v  = k / 14;
        logic        de = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
        logic [11:0] x  = de ? 12'(h - 4) : 12'd0;
        logic [11:0] y  = de ? 12'(v - 2) : 12'd0;
        return {1'b1, (k == 0), (v < 1) ? vpol : ~vpol, (h < 2) ? hpol : ~hpol, de, x, y};
    endfunction

    function automatic logic [28:0] idle_out(logic hpol, logic vpol);
        return {1'b0, 1'b0, ~vpol, ~hpol, 1'b0, 12'd0, 12'd0};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) step();
        checks++;
        if (obs_p !== idle_out(1'b1, 1'b1)) begin
            errors++;
            $display("FAIL reset_idle_pos: got %h expected %h", obs_p, idle_out(1'b1, 1'b1));
        end
        checks++;
        if (obs_n !== idle_out(1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_idle_neg: got %h expected %h", obs_n, idle_out(1'b0, 1'b0));
        end
        rst = 1'b0;
        repeat (2) step();
        checks++;
        if (obs_p !== idle_out(1'b1, 1'b1)) begin
            errors++;
            $display("FAIL idle_after_release: got %h expected %h", obs_p, idle_out(1'b1, 1'b1));
        end
    endtask

    // Start from IDLE and check one complete frame cycle by cycle, plus per-frame totals
    task automatic test_frame();
        int hs_cnt = 0;
        int vs_cnt = 0;
        int de_cnt = 0;
        en = 1'b1;
        step();
        checks++;
        if (obs_p !== idle_out(1'b1, 1'b1)) begin
            errors++;
            $display("FAIL start_latency_early: got %h expected %h", obs_p, idle_out(1'b1, 1'b1));
        end
        step();
        for (int k = 0; k < 98; k++) begin
            checks++;
            if (obs_p !== exp_out(k, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL frame_k%0d: got %h expected %h", k, obs_p, exp_out(k, 1'b1, 1'b1));
            end
            hs_cnt += int'(hs_p);
            vs_cnt += int'(vs_p);
            de_cnt += int'(de_p);
            step();
        end
        checks++;
        if (obs_p !== exp_out(0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL sof_period: got %h expected %h", obs_p, exp_out(0, 1'b1, 1'b1));
        end
        checks++;
        if (hs_cnt != 14) begin
            errors++;
            $display("FAIL hs_per_frame: got %0d expected 14", hs_cnt);
        end
        checks++;
        if (vs_cnt != 14) begin
            errors++;
            $display("FAIL vs_per_frame: got %0d expected 14", vs_cnt);
        end
        checks++;
        if (de_cnt != 32) begin
            errors++;
            $display("FAIL de_per_frame: got %0d expected 32", de_cnt);
        end
    endtask

    // Continues at frame cycle 0; the inverted instance must match with hs/vs flipped
    task automatic test_polarity();
        for (int k = 0; k < 98; k++) begin
            checks++;
            if (obs_n !== exp_out(k, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL polarity_k%0d: got %h expected %h", k, obs_n, exp_out(k, 1'b0, 1'b0));
            end
            step();
        end
    endtask

    // Continues at frame cycle 0; en dropped at 40 lets the frame finish, then IDLE
    task automatic test_stop();
        for (int k = 0; k < 98; k++) begin
            checks++;
            if (obs_p !== exp_out(k, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL stop_k%0d: got %h expected %h", k, obs_p, exp_out(k, 1'b1, 1'b1));
            end
            if (k == 40) en = 1'b0;
            step();
        end
        for (int j = 0; j < 20; j++) begin
            checks++;
            if (obs_p !== idle_out(1'b1, 1'b1)) begin
                errors++;
                $display("FAIL stop_idle_j%0d: got %h expected %h", j, obs_p, idle_out(1'b1, 1'b1));
            end
            step();
        end
    endtask

    // en dropped at 40 and restored at 60: no gap before the next frame
    task automatic test_back_to_back();
        en = 1'b1;
        step();
        step();
        for (int k = 0; k < 98; k++) begin
            checks++;
            if (obs_p !== exp_out(k, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL resume_k%0d: got %h expected %h", k, obs_p, exp_out(k, 1'b1, 1'b1));
            end
            if (k == 40) en = 1'b0;
            if (k == 60) en = 1'b1;
            step();
        end
        checks++;
        if (obs_p !== exp_out(0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL resume_next_sof: got %h expected %h", obs_p, exp_out(0, 1'b1, 1'b1));
        end
    endtask

    // Continues at frame cycle 0 with en=1; reset at cycle 50 forces idle outputs without a clock edge
    task automatic test_reset_mid_frame();
        repeat (50) step();
        checks++;
        if (obs_p !== exp_out(50, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL pre_rst_k50: got %h expected %h", obs_p, exp_out(50, 1'b1, 1'b1));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs_p !== idle_out(1'b1, 1'b1)) begin
            errors++;
            $display("FAIL async_rst_pos: got %h expected %h", obs_p, idle_out(1'b1, 1'b1));
        end
        checks++;
        if (obs_n !== idle_out(1'b0, 1'b0)) begin
            errors++;
            $display("FAIL async_rst_neg: got %h expected %h", obs_n, idle_out(1'b0, 1'b0));
        end
        step();
        step();
        checks++;
        if (obs_p !== idle_out(1'b1, 1'b1)) begin
            errors++;
            $display("FAIL rst_held: got %h expected %h", obs_p, idle_out(1'b1, 1'b1));
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs_p !== idle_out(1'b1, 1'b1)) begin
            errors++;
            $display("FAIL rst_release_first_edge: got %h expected %h", obs_p, idle_out(1'b1, 1'b1));
        end
        step();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (obs_p !== exp_out(k, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL fresh_frame_k%0d: got %h expected %h", k, obs_p, exp_out(k, 1'b1, 1'b1));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_polarity();
        test_stop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
